// File: rtl/note_tone_gen.sv
// Multi-channel solfege tone generator: note code + octave to square
// waves, mixed into one signed sample at a fixed sample rate.
module note_tone_gen #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int CHANNELS  = 2,
  parameter int DIV_W     = 32,
  parameter int AMP_W     = 16,
  parameter int SAMPLE_HZ = 48_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [4*CHANNELS-1:0]     note,
  input  logic [2*CHANNELS-1:0]     octave,
  output logic [DIV_W*CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0]       wave,
  output logic [AMP_W-1:0]          sample_out,
  output logic                      sample_valid
);

  localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int SCW =
    (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AMP =
    ((2 ** (AMP_W - 1)) - 1) / CHANNELS;
  localparam logic [AMP_W-1:0] AMP_S = AMP_W'(AMP);
  localparam logic [SCW-1:0] S_LAST =
    SCW'(SAMPLE_DIV - 1);

  localparam logic [DIV_W-1:0] D_DO1 = DIV_W'(CLK_HZ / 523);
  localparam logic [DIV_W-1:0] D_RE  = DIV_W'(CLK_HZ / 587);
  localparam logic [DIV_W-1:0] D_MI  = DIV_W'(CLK_HZ / 659);
  localparam logic [DIV_W-1:0] D_FA  = DIV_W'(CLK_HZ / 698);
  localparam logic [DIV_W-1:0] D_SOL = DIV_W'(CLK_HZ / 783);
  localparam logic [DIV_W-1:0] D_LA  = DIV_W'(CLK_HZ / 880);
  localparam logic [DIV_W-1:0] D_SI  = DIV_W'(CLK_HZ / 987);
  localparam logic [DIV_W-1:0] D_DO2 = DIV_W'(CLK_HZ / 1046);

  typedef enum logic {
    SILENT,
    PLAYING
  } state_e;

  function automatic logic [DIV_W-1:0] base_div(
    input logic [3:0] code
  );
    logic [DIV_W-1:0] d;
    case (code)
      4'b0001: d = D_DO1;
      4'b0011: d = D_RE;
      4'b0101: d = D_MI;
      4'b1001: d = D_FA;
      4'b0111: d = D_SOL;
      4'b1011: d = D_LA;
      4'b1101: d = D_SI;
      4'b1111: d = D_DO2;
      default: d = '0;
    endcase
    return d;
  endfunction

  logic                  en_q;
  logic [4*CHANNELS-1:0] note_q;
  logic [2*CHANNELS-1:0] oct_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      note_q <= '0;
      oct_q  <= '0;
    end else begin
      en_q   <= enable;
      note_q <= note;
      oct_q  <= octave;
    end
  end

  logic [CHANNELS-1:0] play_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;
    logic [DIV_W-1:0] req;
    logic [DIV_W-1:0] half;
    logic             bnd;

    assign req = en_q
      ? (base_div(note_q[4*i +: 4]) >> oct_q[2*i +: 2])
      : '0;
    assign half = div_q >> 1;
    assign bnd  = (cnt_q + DIV_W'(1)) >= half;

    // Divisor changes while playing only land on a wave edge.
    always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      wave_d  = wave_q;
      if (!en_q) begin
        state_d = SILENT;
        div_d   = '0;
        cnt_d   = '0;
        wave_d  = 1'b0;
      end else if (state_q == SILENT) begin
        if (req != '0) begin
          state_d = PLAYING;
          div_d   = req;
          cnt_d   = '0;
          wave_d  = 1'b0;
        end
      end else if (bnd) begin
        cnt_d = '0;
        if (req == '0) begin
          state_d = SILENT;
          div_d   = '0;
          wave_d  = 1'b0;
        end else begin
          div_d  = req;
          wave_d = ~wave_q;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= SILENT;
        div_q   <= '0;
        cnt_q   <= '0;
        wave_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        div_q   <= div_d;
        cnt_q   <= cnt_d;
        wave_q  <= wave_d;
      end
    end

    assign div_out[i*DIV_W +: DIV_W] = div_q;
    assign wave[i]   = wave_q;
    assign play_w[i] = (state_q == PLAYING);
  end

  logic [AMP_W-1:0] mix;

  always_comb begin
    mix = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (play_w[i]) begin
        mix = wave[i] ? mix + AMP_S : mix - AMP_S;
      end
    end
  end

  logic [SCW-1:0]   scnt_q, scnt_d;
  logic [AMP_W-1:0] smp_q, smp_d;
  logic             sv_q, sv_d;

  always_comb begin
    scnt_d = scnt_q + SCW'(1);
    smp_d  = smp_q;
    sv_d   = 1'b0;
    if (scnt_q == S_LAST) begin
      scnt_d = '0;
      smp_d  = mix;
      sv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      smp_q  <= '0;
      sv_q   <= 1'b0;
    end else begin
      scnt_q <= scnt_d;
      smp_q  <= smp_d;
      sv_q   <= sv_d;
    end
  end

  assign sample_out   = smp_q;
  assign sample_valid = sv_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: timed checks plus a sample scoreboard.
module tb_note_tone_gen;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  note   = '0;
  logic [3:0]  octave = '0;
  logic [63:0] div_out;
  logic [1:0]  wave;
  logic [15:0] sample_out;
  logic        sample_valid;

  int     n_chk  = 0;
  int     n_fail = 0;
  int     gap    = 0;
  longint cyc    = 0;
  longint exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  note_tone_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .note         (note),
    .octave       (octave),
    .div_out      (div_out),
    .wave         (wave),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  task automatic chk(
    input string             tag,
    input logic signed [63:0] got,
    input logic signed [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic longint dv(input int c);
    return longint'(div_out[c*32 +: 32]);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_wave(input int c, input logic lvl);
    int n = 0;
    while (wave[c] !== lvl && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("wave_timeout", wave[c], lvl);
  endtask

  // Sample monitor: period check and scoreboard pop.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      gap = 0;
    end else begin
      gap++;
      if (sample_valid) begin
        chk("sample_period", gap, 1041);
        gap = 0;
        if (exp_q.size() > 0)
          chk("sample", $signed(sample_out),
              exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0, t1;
    int     n;

    tick(3);
    chk("rst_div", div_out, 0);
    chk("rst_wave", wave, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_valid", sample_valid, 0);
    rst_n = 1'b1;
    tick(2);

    enable = 1'b1;
    note   = 8'h01;
    octave = 4'b0000;
    tick(1);
    chk("do1_lat1", dv(0), 0);
    tick(1);
    chk("do1_div", dv(0), 95602);
    chk("ch1_div", dv(1), 0);
    chk("ch1_wave", wave[1], 0);
    t0 = cyc;
    exp_q.push_back(-16383);
    wait_wave(0, 1'b1);
    chk("do1_half", cyc - t0, 47801);
    chk("ch1_idle", wave[1], 0);
    exp_q.push_back(16383);
    drain();

    enable = 1'b0;
    tick(1);
    chk("en_lat1", dv(0), 95602);
    tick(1);
    chk("en_div", dv(0), 0);
    chk("en_wave", wave[0], 0);
    exp_q.push_back(0);
    drain();

    note   = 8'hBB;
    octave = 4'b1010;
    enable = 1'b1;
    tick(2);
    chk("la_div0", dv(0), 14204);
    chk("la_div1", dv(1), 14204);
    t0 = cyc;
    exp_q.push_back(-32766);
    drain();
    wait_wave(0, 1'b1);
    chk("la_rise", cyc - t0, 7102);
    chk("la_phase", wave[1], 1);
    exp_q.push_back(32766);
    drain();
    wait_wave(0, 1'b0);
    chk("la_fall", cyc - t0, 14204);
    enable = 1'b0;
    tick(2);

    note   = 8'h01;
    octave = 4'b0011;
    enable = 1'b1;
    tick(2);
    chk("do1o3_div", dv(0), 11950);
    t0 = cyc;
    tick(2000);
    note = 8'h0F;
    tick(3);
    chk("pend_hold", dv(0), 11950);
    wait_wave(0, 1'b1);
    chk("pend_at", cyc - t0, 5975);
    chk("pend_div", dv(0), 5975);
    t1 = cyc;
    wait_wave(0, 1'b0);
    chk("do2_high", cyc - t1, 2987);
    t1 = cyc;
    note = 8'h00;
    tick(3);
    chk("stop_hold", dv(0), 5975);
    n = 0;
    while (dv(0) != 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("stop_at", cyc - t1, 2987);
    chk("stop_wave", wave[0], 0);
    chk("ch1_quiet", dv(1), 0);

    note   = 8'h01;
    octave = 4'b0000;
    tick(2);
    chk("re_div", dv(0), 95602);
    exp_q.push_back(-16383);
    drain();
    tick(100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_div", div_out, 0);
    chk("arst_wave", wave, 0);
    chk("arst_sample", sample_out, 0);
    chk("arst_valid", sample_valid, 0);
    tick(3);
    rst_n = 1'b1;
    exp_q.push_back(-16383);
    tick(2);
    n = 2;
    chk("post_rst_div", dv(0), 95602);
    while (!sample_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("first_valid", n, 1041);
    tick(2);
    chk("post_rst_sb", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
